// File: rtl/rr_mem_sequencer.sv
// Burst sequencer and round-robin arbiter for the residual-vector (RR) memory.
// One read client and one write client; one burst in flight at a time.
module rr_mem_sequencer #(
   parameter int ELEMENT_WIDTH = 64,
   parameter int NO_OF_UNITS   = 8,
   parameter int ADDRESS_WIDTH = 20,
   parameter int LEN_WIDTH     = 11,
   parameter int MEM_DEPTH     = 1001
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   rd_req,
   input  logic [ADDRESS_WIDTH-1:0]               rd_start_addr,
   input  logic [LEN_WIDTH-1:0]                   rd_len,
   output logic                                   rd_grant,
   output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   rd_data,
   output logic                                   rd_valid,
   input  logic                                   rd_ready,
   output logic                                   rd_done,
   input  logic                                   wr_req,
   input  logic [ADDRESS_WIDTH-1:0]               wr_start_addr,
   input  logic [LEN_WIDTH-1:0]                   wr_len,
   output logic                                   wr_grant,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   wr_data,
   input  logic                                   wr_valid,
   output logic                                   wr_ready,
   output logic                                   wr_done,
   output logic [ADDRESS_WIDTH-1:0]               mem_read_address,
   input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   mem_read_data,
   output logic [ADDRESS_WIDTH-1:0]               mem_write_address,
   output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   mem_write_data,
   output logic                                   mem_write_enable,
   output logic                                   busy
);
   localparam int W = NO_OF_UNITS * ELEMENT_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

   state_t                   state_q, state_d;
   logic                     last_wr_q, last_wr_d;
   logic [ADDRESS_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_WIDTH-1:0]     len_q, len_d;
   logic [LEN_WIDTH-1:0]     count_q, count_d;
   logic [W-1:0]             rd_data_q, rd_data_d;
   logic                     rd_valid_q, rd_valid_d;
   logic                     rd_grant_q, rd_grant_d;
   logic                     wr_grant_q, wr_grant_d;
   logic                     rd_done_q, rd_done_d;
   logic                     wr_done_q, wr_done_d;

   logic grant_rd, rd_issue, rd_end, wr_fire, wr_end;

   function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDRESS_WIDTH'(1);
   endfunction

   // On contention the read side wins unless it was the last one served.
   assign grant_rd = rd_req && (!wr_req || last_wr_q);

   assign rd_issue = (state_q == RD_BURST) && (count_q < len_q) && (!rd_valid_q || rd_ready);
   assign rd_end   = (state_q == RD_BURST) && (count_q == len_q) && (!rd_valid_q || rd_ready);
   assign wr_ready = (state_q == WR_BURST) && (count_q < len_q);
   assign wr_fire  = wr_ready && wr_valid;
   assign wr_end   = (wr_fire && ((count_q + LEN_WIDTH'(1)) == len_q)) ||
                     ((state_q == WR_BURST) && (count_q == len_q));

   always_comb begin
      state_d    = state_q;
      last_wr_d  = last_wr_q;
      cur_addr_d = cur_addr_q;
      len_d      = len_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      rd_grant_d = 1'b0;
      wr_grant_d = 1'b0;
      rd_done_d  = 1'b0;
      wr_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_rd) begin
               state_d    = RD_BURST;
               rd_grant_d = 1'b1;
               last_wr_d  = 1'b0;
               cur_addr_d = rd_start_addr;
               len_d      = rd_len;
               count_d    = '0;
            end else if (wr_req) begin
               state_d    = WR_BURST;
               wr_grant_d = 1'b1;
               last_wr_d  = 1'b1;
               cur_addr_d = wr_start_addr;
               len_d      = wr_len;
               count_d    = '0;
            end
         end
         RD_BURST: begin
            if (rd_issue) begin
               rd_data_d  = mem_read_data;
               rd_valid_d = 1'b1;
               cur_addr_d = next_addr(cur_addr_q);
               count_d    = count_q + LEN_WIDTH'(1);
            end else if (rd_valid_q && rd_ready) begin
               rd_valid_d = 1'b0;
            end
            if (rd_end) begin
               rd_done_d = 1'b1;
               state_d   = IDLE;
            end
         end
         WR_BURST: begin
            if (wr_fire) begin
               cur_addr_d = next_addr(cur_addr_q);
               count_d    = count_q + LEN_WIDTH'(1);
            end
            if (wr_end) begin
               wr_done_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_wr_q  <= 1'b1;
         cur_addr_q <= '0;
         len_q      <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_grant_q <= 1'b0;
         wr_grant_q <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_wr_q  <= last_wr_d;
         cur_addr_q <= cur_addr_d;
         len_q      <= len_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_grant_q <= rd_grant_d;
         wr_grant_q <= wr_grant_d;
         rd_done_q  <= rd_done_d;
         wr_done_q  <= wr_done_d;
      end
   end

   assign rd_grant          = rd_grant_q;
   assign wr_grant          = wr_grant_q;
   assign rd_done           = rd_done_q;
   assign wr_done           = wr_done_q;
   assign rd_data           = rd_data_q;
   assign rd_valid          = rd_valid_q;
   assign busy              = (state_q != IDLE);
   assign mem_read_address  = cur_addr_q;
   // Write port is a pass-through; the memory captures on the handshake edge.
   assign mem_write_address = cur_addr_q;
   assign mem_write_data    = wr_data;
   assign mem_write_enable  = wr_fire;

endmodule
